// File: rtl/mips_cpu_harvard_run_ctrl_if.sv
// Bundle between the run controller, the CPU it sequences and the host that starts runs.
// The slave modport is the controller's view; master is the environment's view.
interface mips_cpu_harvard_run_ctrl_if;
    logic        start;
    logic        cpu_active;
    logic [31:0] cpu_register_v0;
    logic        cpu_reset;
    logic        cpu_clk_enable;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        no_start;
    logic [31:0] result;
    logic [31:0] cycle_count;

    modport slave (
        input  start, cpu_active, cpu_register_v0,
        output cpu_reset, cpu_clk_enable, busy, done, timeout, no_start, result, cycle_count
    );

    modport master (
        output start, cpu_active, cpu_register_v0,
        input  cpu_reset, cpu_clk_enable, busy, done, timeout, no_start, result, cycle_count
    );
endinterface

// File: rtl/mips_cpu_harvard_run_ctrl.sv
// Sequences reset, start check, timed execution and result capture for mips_cpu_harvard.
// CPU control outputs are decoded from the state; everything else is registered.
module mips_cpu_harvard_run_ctrl #(
    parameter int unsigned RESET_CYCLES   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 100
) (
    input  logic                           clk,
    input  logic                           reset,
    mips_cpu_harvard_run_ctrl_if.slave     bus
);

    localparam int unsigned RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned CW  = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_CHECK,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [RCW-1:0]  rst_cnt_q, rst_cnt_d;
    logic [CW-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [31:0]     result_q, result_d;
    logic            timeout_q, timeout_d;
    logic            no_start_q, no_start_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rst_cnt_q   <= '0;
            cycle_cnt_q <= '0;
            result_q    <= '0;
            timeout_q   <= 1'b0;
            no_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            result_q    <= result_d;
            timeout_q   <= timeout_d;
            no_start_q  <= no_start_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        result_d    = result_q;
        timeout_d   = timeout_q;
        no_start_d  = no_start_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d     = S_RESET;
                    rst_cnt_d   = RCW'(RESET_CYCLES - 1);
                    cycle_cnt_d = '0;
                    result_d    = '0;
                    timeout_d   = 1'b0;
                    no_start_d  = 1'b0;
                end
            end
            S_RESET: begin
                if (rst_cnt_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    rst_cnt_d = rst_cnt_q - RCW'(1);
                end
            end
            S_CHECK: begin
                if (bus.cpu_active) begin
                    state_d = S_RUN;
                end else begin
                    state_d    = S_DONE;
                    no_start_d = 1'b1;
                end
            end
            S_RUN: begin
                if (!bus.cpu_active) begin
                    state_d = S_DRAIN;
                end else begin
                    cycle_cnt_d = cycle_cnt_q + CW'(1);
                    // Leaving RUN at the limit keeps the counter saturated at TIMEOUT_CYCLES
                    if (cycle_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                        result_d  = bus.cpu_register_v0;
                    end
                end
            end
            S_DRAIN: begin
                state_d  = S_DONE;
                result_d = bus.cpu_register_v0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cpu_reset      = (state_q == S_IDLE) || (state_q == S_RESET);
    assign bus.cpu_clk_enable = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.busy           = (state_q == S_RESET) || (state_q == S_CHECK) ||
                                (state_q == S_RUN)   || (state_q == S_DRAIN);
    assign bus.done           = (state_q == S_DONE);
    assign bus.timeout        = timeout_q;
    assign bus.no_start       = no_start_q;
    assign bus.result         = result_q;
    assign bus.cycle_count    = cycle_cnt_q;

endmodule

// File: tb/tb_mips_cpu_harvard_run_ctrl.sv
// Directed bench: instance A (RESET_CYCLES=1, TIMEOUT_CYCLES=10) and B (RESET_CYCLES=3).
module tb_mips_cpu_harvard_run_ctrl;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   errors;
    int   checks;

    mips_cpu_harvard_run_ctrl_if ifa ();
    mips_cpu_harvard_run_ctrl_if ifb ();

    mips_cpu_harvard_run_ctrl #(.RESET_CYCLES(1), .TIMEOUT_CYCLES(10)) u_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ifa.slave)
    );

    mips_cpu_harvard_run_ctrl #(.RESET_CYCLES(3), .TIMEOUT_CYCLES(10)) u_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        ifa.start = 1'b0; ifa.cpu_active = 1'b0; ifa.cpu_register_v0 = 32'h0;
        ifb.start = 1'b0; ifb.cpu_active = 1'b0; ifb.cpu_register_v0 = 32'h0;
        tick();
        tick();

        // Reset state
        chk("rst_cpu_reset", 32'(ifa.cpu_reset), 32'd1);
        chk("rst_clk_en",    32'(ifa.cpu_clk_enable), 32'd0);
        chk("rst_busy",      32'(ifa.busy), 32'd0);
        chk("rst_done",      32'(ifa.done), 32'd0);
        chk("rst_timeout",   32'(ifa.timeout), 32'd0);
        chk("rst_no_start",  32'(ifa.no_start), 32'd0);
        chk("rst_result",    ifa.result, 32'd0);
        chk("rst_count",     ifa.cycle_count, 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();
        chk("idle_busy", 32'(ifa.busy), 32'd0);

        // Normal halt: 7 active RUN edges, then v0=0x2A
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        chk("nh_reset_cpu_reset", 32'(ifa.cpu_reset), 32'd1);
        chk("nh_reset_clk_en",    32'(ifa.cpu_clk_enable), 32'd1);
        chk("nh_reset_busy",      32'(ifa.busy), 32'd1);
        tick();
        chk("nh_check_cpu_reset", 32'(ifa.cpu_reset), 32'd0);
        ifa.cpu_active = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("nh_run_count", ifa.cycle_count, 32'd7);
        chk("nh_run_busy",  32'(ifa.busy), 32'd1);
        ifa.cpu_active = 1'b0;
        ifa.cpu_register_v0 = 32'h0000_002A;
        tick();
        chk("nh_drain_busy", 32'(ifa.busy), 32'd1);
        chk("nh_drain_done", 32'(ifa.done), 32'd0);
        tick();
        chk("nh_done",     32'(ifa.done), 32'd1);
        chk("nh_result",   ifa.result, 32'h0000_002A);
        chk("nh_count",    ifa.cycle_count, 32'd7);
        chk("nh_timeout",  32'(ifa.timeout), 32'd0);
        chk("nh_no_start", 32'(ifa.no_start), 32'd0);
        chk("nh_clk_en",   32'(ifa.cpu_clk_enable), 32'd0);
        chk("nh_cpu_reset", 32'(ifa.cpu_reset), 32'd0);
        tick();
        chk("nh_done_hold_result", ifa.result, 32'h0000_002A);

        // Timeout: active never falls, limit 10
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        chk("to_cleared_result", ifa.result, 32'd0);
        chk("to_cleared_count",  ifa.cycle_count, 32'd0);
        tick();
        ifa.cpu_active = 1'b1;
        ifa.cpu_register_v0 = 32'h0000_0055;
        tick();
        for (int i = 0; i < 9; i++) tick();
        chk("to_before_limit_busy",  32'(ifa.busy), 32'd1);
        chk("to_before_limit_count", ifa.cycle_count, 32'd9);
        tick();
        chk("to_done",    32'(ifa.done), 32'd1);
        chk("to_timeout", 32'(ifa.timeout), 32'd1);
        chk("to_count",   ifa.cycle_count, 32'd10);
        chk("to_result",  ifa.result, 32'h0000_0055);
        tick();
        chk("to_count_hold", ifa.cycle_count, 32'd10);

        // No start: active low through CHECK
        ifa.cpu_active = 1'b0;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        chk("ns_cleared_timeout", 32'(ifa.timeout), 32'd0);
        tick();
        chk("ns_check_busy", 32'(ifa.busy), 32'd1);
        tick();
        chk("ns_done",     32'(ifa.done), 32'd1);
        chk("ns_no_start", 32'(ifa.no_start), 32'd1);
        chk("ns_result",   ifa.result, 32'd0);
        chk("ns_count",    ifa.cycle_count, 32'd0);

        // Halt on the boundary: active falls on the 10th RUN edge
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        chk("bd_cleared_no_start", 32'(ifa.no_start), 32'd0);
        tick();
        ifa.cpu_active = 1'b1;
        ifa.cpu_register_v0 = 32'h0000_0099;
        tick();
        for (int i = 0; i < 9; i++) tick();
        ifa.cpu_active = 1'b0;
        tick();
        chk("bd_drain_busy",    32'(ifa.busy), 32'd1);
        chk("bd_drain_timeout", 32'(ifa.timeout), 32'd0);
        chk("bd_drain_count",   ifa.cycle_count, 32'd9);
        tick();
        chk("bd_done",    32'(ifa.done), 32'd1);
        chk("bd_timeout", 32'(ifa.timeout), 32'd0);
        chk("bd_count",   ifa.cycle_count, 32'd9);
        chk("bd_result",  ifa.result, 32'h0000_0099);

        // Reset mid-run, with a simultaneous start that must be ignored
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        tick();
        ifa.cpu_active = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        chk("mr_run_count", ifa.cycle_count, 32'd3);
        rst_a = 1'b1;
        ifa.start = 1'b1;
        tick();
        rst_a = 1'b0;
        ifa.start = 1'b0;
        chk("mr_cpu_reset", 32'(ifa.cpu_reset), 32'd1);
        chk("mr_clk_en",    32'(ifa.cpu_clk_enable), 32'd0);
        chk("mr_busy",      32'(ifa.busy), 32'd0);
        chk("mr_done",      32'(ifa.done), 32'd0);
        chk("mr_count",     ifa.cycle_count, 32'd0);
        chk("mr_result",    ifa.result, 32'd0);
        tick();
        chk("mr_start_ignored", 32'(ifa.busy), 32'd0);
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        ifa.cpu_active = 1'b0;
        ifa.cpu_register_v0 = 32'h0000_0011;
        tick();
        tick();
        chk("mr_fresh_done",   32'(ifa.done), 32'd1);
        chk("mr_fresh_count",  ifa.cycle_count, 32'd2);
        chk("mr_fresh_result", ifa.result, 32'h0000_0011);

        // Restart and ignore on instance B (RESET_CYCLES=3)
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rb_reset_hold", 32'(ifb.cpu_reset), 32'd1);
            tick();
        end
        chk("rb_check_cpu_reset", 32'(ifb.cpu_reset), 32'd0);
        ifb.cpu_active = 1'b1;
        tick();
        tick();
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        chk("rb_ignore_busy",      32'(ifb.busy), 32'd1);
        chk("rb_ignore_cpu_reset", 32'(ifb.cpu_reset), 32'd0);
        chk("rb_ignore_count",     ifb.cycle_count, 32'd2);
        ifb.cpu_active = 1'b0;
        ifb.cpu_register_v0 = 32'h0000_0077;
        tick();
        tick();
        chk("rb_done",   32'(ifb.done), 32'd1);
        chk("rb_result", ifb.result, 32'h0000_0077);
        chk("rb_count",  ifb.cycle_count, 32'd2);
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        chk("rb2_result",   ifb.result, 32'd0);
        chk("rb2_timeout",  32'(ifb.timeout), 32'd0);
        chk("rb2_no_start", 32'(ifb.no_start), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("rb2_reset_hold", 32'(ifb.cpu_reset), 32'd1);
            tick();
        end
        chk("rb2_reset_release", 32'(ifb.cpu_reset), 32'd0);
        tick();
        chk("rb2_no_start_done", 32'(ifb.no_start), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_cpu_harvard_run_ctrl.md
# mips_cpu_harvard_run_ctrl

Run controller that sits directly upstream of `mips_cpu_harvard` and drives its reset and `clk_enable`. Each run releases the CPU from reset and checks that it raised `active`. It then counts execution cycles until the CPU halts or a timeout expires, and latches `register_v0` as the run result. This moves the reset/halt/timeout sequencing out of the testbench into synthesizable RTL, so the same flow works on FPGA and in simulation.

## Interface
- `RESET_CYCLES`, default 1: cycles `cpu_reset` is held high per run (legal values are 1 or more).
- `TIMEOUT_CYCLES`, default 100: maximum number of active cycles before a run is aborted (legal values are 1 or more).
- `clk` input, 1 bit: the single clock. All logic is clocked on the rising edge.
- `reset` input, 1 bit: synchronous, active-high reset of the controller.
- `start` input, 1 bit: requests a run. Sampled only in IDLE or DONE.
- `cpu_active` input, 1 bit: the CPU's `active` output.
- `cpu_register_v0` input, 32 bits: the CPU's `register_v0` output.
- `cpu_reset` output, 1 bit: drives the CPU's `reset`.
- `cpu_clk_enable` output, 1 bit: drives the CPU's `clk_enable`.
- `busy` output, 1 bit: high while in RESET, CHECK, RUN or DRAIN.
- `done` output, 1 bit: high in DONE. It is a level, not a pulse.
- `timeout` output, 1 bit: the last run hit `TIMEOUT_CYCLES`.
- `no_start` output, 1 bit: the CPU did not assert `active` after reset.
- `result` output, 32 bits: `register_v0` latched at the end of the run.
- `cycle_count` output, 32 bits: number of RUN cycles sampled with `cpu_active`=1.

## Operation
- States are IDLE, RESET, CHECK, RUN, DRAIN and DONE.
- IDLE:
  - Outputs: `cpu_reset`=1, `cpu_clk_enable`=0.
  - `start`=1 moves to RESET and clears `timeout`, `no_start`, `result` and `cycle_count`.
- RESET:
  - Outputs: `cpu_reset`=1, `cpu_clk_enable`=1.
  - Lasts exactly `RESET_CYCLES` cycles, timed by an internal down-counter, then goes to CHECK.
- CHECK:
  - Outputs: `cpu_reset`=0, `cpu_clk_enable`=1. Lasts exactly one cycle.
  - The first CPU edge out of reset happens in this state.
  - `cpu_active` is sampled at the end of CHECK. If 1, go to RUN. If 0, set `no_start`=1 and go to DONE; `result` stays 0.
- RUN:
  - Outputs: `cpu_reset`=0, `cpu_clk_enable`=1.
  - Each edge where `cpu_active`=1 increments `cycle_count`.
  - If `cpu_active`=1 and `cycle_count`==`TIMEOUT_CYCLES`-1 on that edge: set `timeout`=1, latch `result`, go to DONE. `cycle_count` ends at `TIMEOUT_CYCLES`.
  - `cpu_active`=0 moves to DRAIN.
- DRAIN:
  - Outputs: `cpu_reset`=0, `cpu_clk_enable`=1. Lasts one cycle, giving the CPU one more edge after halting.
  - At its end, latch `result` from `cpu_register_v0` and go to DONE.
- DONE:
  - Outputs: `cpu_reset`=0, `cpu_clk_enable`=0. The CPU is frozen with its state intact for inspection.
  - `result` and the flags hold.
  - `start`=1 behaves exactly as in IDLE.
- `start` is ignored while `busy`=1.
- Counter width: `cycle_count` saturates at `TIMEOUT_CYCLES` and never wraps.

## Timing
- Reset values (controller `reset`=1 at an edge): state IDLE, `cpu_reset`=1, `cpu_clk_enable`=0, `busy`=0, `done`=0, `timeout`=0, `no_start`=0, `result`=0, `cycle_count`=0.
- All outputs are registered or decoded directly from the state; there is no combinational path from inputs to outputs.
- `reset` has priority over every other input and takes effect mid-run. `cpu_reset` returns to 1 on the next cycle, so the CPU is held safe.
- If `start` is sampled at edge k:
  - RESET covers cycles k+1 to k+`RESET_CYCLES`.
  - CHECK is cycle k+`RESET_CYCLES`+1.
  - RUN begins at k+`RESET_CYCLES`+2.
- Halt latency: `cpu_active` sampled 0 at edge m gives DRAIN for one cycle. `done`=1 and `result` are valid from the cycle after edge m+1.
- Simultaneous halt and timeout: if `cpu_active`=0 on the edge that would reach the limit, the halt wins. `timeout` stays 0 and the run goes through DRAIN.
- A `start` arriving in the same cycle as the controller `reset` is ignored.

## Test plan
- Normal halt:
  - Stimulus: `RESET_CYCLES`=1. Pulse `start`. The CPU model raises active after reset, holds it for 7 RUN edges, then drops it with v0=0x0000_002A.
  - Required: `done`=1, `result`=0x2A, `cycle_count`=7, `timeout`=0, `no_start`=0, `cpu_clk_enable`=0 in DONE.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=10, active never falls.
  - Required: DONE reached after exactly 10 RUN cycles, `timeout`=1, `cycle_count`=10.
- No start:
  - Stimulus: active stays 0 through CHECK.
  - Required: `no_start`=1, `result`=0, `cycle_count`=0, DONE entered directly from CHECK.
- Halt on the boundary:
  - Stimulus: `TIMEOUT_CYCLES`=10, active falls on the 10th RUN edge.
  - Required: `timeout`=0, DRAIN is taken, `cycle_count`=9.
- Reset mid-run:
  - Stimulus: assert `reset` during RUN at cycle 5.
  - Required: next cycle shows IDLE, `cpu_reset`=1, all flags and counters 0. A fresh `start` then completes a normal run.
- Restart and ignore:
  - Stimulus: pulse `start` while in RUN, then again in DONE; use `RESET_CYCLES`=3.
  - Required: the first `start` has no effect. The second clears `result`, `timeout` and `no_start` and holds `cpu_reset` high for exactly 3 cycles.
